// File: rtl/context_scheduler_if.sv
// Scheduler-side bundle of context_scheduler: timer/CPU events, process creation and PC-load outputs.
// switch_count exists only when SCHED_STATS_EN is defined.
interface context_scheduler_if #(
  parameter int PID_W = 3
);
  logic             interrupt;
  logic             finish;
  logic [31:0]      pc_current;
  logic             sched_start;
  logic             proc_create;
  logic [PID_W-1:0] create_id;
  logic [31:0]      create_pc;
  logic [31:0]      create_quantum;
  logic [31:0]      pc_load;
  logic             pc_load_valid;
  logic             FLAG_timer;
  logic [31:0]      quantum;
  logic [PID_W-1:0] current_pid;
  logic             busy;
  logic             all_done;
`ifdef SCHED_STATS_EN
  logic [31:0]      switch_count;
`endif

  modport master (
    output interrupt, finish, pc_current, sched_start,
    output proc_create, create_id, create_pc, create_quantum,
    input  pc_load, pc_load_valid, FLAG_timer, quantum,
`ifdef SCHED_STATS_EN
    input  switch_count,
`endif
    input  current_pid, busy, all_done
  );

  modport slave (
    input  interrupt, finish, pc_current, sched_start,
    input  proc_create, create_id, create_pc, create_quantum,
    output pc_load, pc_load_valid, FLAG_timer, quantum,
`ifdef SCHED_STATS_EN
    output switch_count,
`endif
    output current_pid, busy, all_done
  );
endinterface

// File: rtl/context_scheduler.sv
// Round-robin preemptive context scheduler: saves the preempted PC, picks the next active slot, re-arms the timer.
// Optional SCHED_STATS_EN adds a free-running context-switch counter on switch_count.
module context_scheduler #(
  parameter int NPROC = 8,
  parameter int PID_W = 3
) (
  input logic                 clock,
  input logic                 reset,
  context_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAVE   = 3'd1,
    SELECT = 3'd2,
    LOAD   = 3'd3,
    RUN    = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;

  logic [31:0]      saved_pc_r     [NPROC];
  logic [31:0]      slot_quantum_r [NPROC];
  logic [NPROC-1:0] active_r;

  logic [PID_W-1:0] current_pid_r;
  logic [PID_W-1:0] next_pid_r;
  logic             from_start_r;
  logic             all_done_r;
  logic [31:0]      pc_load_r;
  logic [31:0]      quantum_r;
  logic             strobe_r;
  logic             busy_r;

  logic [PID_W-1:0] search_base_s;
  logic [PID_W-1:0] found_pid_s;
  logic             found_s;
  logic             create_ok_s;

  // First active slot at or after base, wrapping; lowest offset wins so base-1 is tried last.
  function automatic logic [PID_W:0] rr_search(
    input logic [NPROC-1:0] act,
    input logic [PID_W-1:0] base
  );
    logic [PID_W:0]   result;
    logic [PID_W-1:0] idx;
    result = '0;
    idx    = '0;
    for (int i = NPROC - 1; i >= 0; i--) begin
      idx = base + PID_W'(i);
      if (act[idx]) begin
        result = {1'b1, idx};
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Search origin and result of the round-robin scan over the registered active vector.
  always_comb begin
    search_base_s = '0;
    if (from_start_r) begin
      search_base_s = '0;
    end else begin
      search_base_s = current_pid_r + PID_W'(1);
    end
    {found_s, found_pid_s} = rr_search(active_r, search_base_s);
  end

  // Creation is refused for the running slot while its context is live or being saved.
  always_comb begin
    create_ok_s = 1'b0;
    if (bus.proc_create && !(((state_r == RUN) || (state_r == SAVE)) &&
                             (bus.create_id == current_pid_r))) begin
      create_ok_s = 1'b1;
    end else begin
      create_ok_s = 1'b0;
    end
  end

  // Next-state logic; finish has priority over interrupt in RUN.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.sched_start) begin
          state_s = SELECT;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (bus.finish) begin
          state_s = SELECT;
        end else if (bus.interrupt) begin
          state_s = SAVE;
        end else begin
          state_s = RUN;
        end
      end
      SAVE: begin
        state_s = SELECT;
      end
      SELECT: begin
        if (found_s) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        state_s = RUN;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Process table: creation, PC save on preemption, deactivation on finish.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NPROC; i++) begin
        saved_pc_r[i]     <= 32'd0;
        slot_quantum_r[i] <= 32'd0;
      end
      active_r <= '0;
    end else begin
      if (create_ok_s) begin
        saved_pc_r[bus.create_id]     <= bus.create_pc;
        slot_quantum_r[bus.create_id] <= bus.create_quantum;
        active_r[bus.create_id]       <= 1'b1;
      end
      if (state_r == SAVE) begin
        saved_pc_r[current_pid_r] <= bus.pc_current;
      end
      if ((state_r == RUN) && bus.finish) begin
        active_r[current_pid_r] <= 1'b0;
      end
    end
  end

  // Control registers and registered outputs; strobes follow the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      current_pid_r <= '0;
      next_pid_r    <= '0;
      from_start_r  <= 1'b0;
      all_done_r    <= 1'b0;
      pc_load_r     <= 32'd0;
      quantum_r     <= 32'd0;
      strobe_r      <= 1'b0;
      busy_r        <= 1'b1;
    end else begin
      strobe_r <= (state_s == LOAD);
      busy_r   <= (state_s != RUN);
      case (state_r)
        IDLE: begin
          if (bus.sched_start) begin
            from_start_r <= 1'b1;
            all_done_r   <= 1'b0;
          end
        end
        SELECT: begin
          from_start_r <= 1'b0;
          if (found_s) begin
            next_pid_r <= found_pid_s;
            pc_load_r  <= saved_pc_r[found_pid_s];
            quantum_r  <= slot_quantum_r[found_pid_s];
          end else begin
            all_done_r <= 1'b1;
          end
        end
        LOAD: begin
          current_pid_r <= next_pid_r;
        end
        default: begin
          current_pid_r <= current_pid_r;
        end
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  logic [31:0] switch_count_r;

  // Counts LOAD cycles, wrapping naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      switch_count_r <= 32'd0;
    end else if (state_r == LOAD) begin
      switch_count_r <= switch_count_r + 32'd1;
    end else begin
      switch_count_r <= switch_count_r;
    end
  end

  assign bus.switch_count = switch_count_r;
`endif

  assign bus.pc_load       = pc_load_r;
  assign bus.pc_load_valid = strobe_r;
  assign bus.FLAG_timer    = strobe_r;
  assign bus.quantum       = quantum_r;
  assign bus.current_pid   = current_pid_r;
  assign bus.busy          = busy_r;
  assign bus.all_done      = all_done_r;

endmodule

// File: tb/tb_context_scheduler.sv
// Directed bench for context_scheduler: start, round-robin preemption, finish, single process, corner events, reset.
module tb_context_scheduler;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  context_scheduler_if #(.PID_W(3)) bus ();

  context_scheduler #(.NPROC(8), .PID_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic create(input logic [2:0] id, input logic [31:0] pc, input logic [31:0] q);
    bus.proc_create    = 1'b1;
    bus.create_id      = id;
    bus.create_pc      = pc;
    bus.create_quantum = q;
    tick();
    bus.proc_create    = 1'b0;
  endtask

  task automatic start();
    bus.sched_start = 1'b1;
    tick();
    bus.sched_start = 1'b0;
  endtask

  task automatic irq(input logic [31:0] pc);
    bus.pc_current = pc;
    bus.interrupt  = 1'b1;
    tick();
    bus.interrupt  = 1'b0;
  endtask

  task automatic fin();
    bus.finish = 1'b1;
    tick();
    bus.finish = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc_load"}, bus.pc_load, 32'h0);
    chk({tag, "_valid"}, {31'd0, bus.pc_load_valid}, 32'd0);
    chk({tag, "_flag"}, {31'd0, bus.FLAG_timer}, 32'd0);
    chk({tag, "_quantum"}, bus.quantum, 32'd0);
    chk({tag, "_pid"}, {29'd0, bus.current_pid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, "_all_done"}, {31'd0, bus.all_done}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.interrupt      = 1'b0;
    bus.finish         = 1'b0;
    bus.pc_current     = 32'd0;
    bus.sched_start    = 1'b0;
    bus.proc_create    = 1'b0;
    bus.create_id      = 3'd0;
    bus.create_pc      = 32'd0;
    bus.create_quantum = 32'd0;
    tick();
    tick();
    chk_reset("rst");
    reset = 1'b0;

    // 1: basic start
    create(3'd0, 32'h100, 32'd10);
    create(3'd2, 32'h200, 32'd20);
    chk("idle_busy", {31'd0, bus.busy}, 32'd1);
    start();
    chk("start_sel_valid", {31'd0, bus.pc_load_valid}, 32'd0);
    tick();
    chk("start_load_valid", {31'd0, bus.pc_load_valid}, 32'd1);
    chk("start_load_flag", {31'd0, bus.FLAG_timer}, 32'd1);
    chk("start_pc_load", bus.pc_load, 32'h100);
    chk("start_quantum", bus.quantum, 32'd10);
    tick();
    chk("start_run_valid", {31'd0, bus.pc_load_valid}, 32'd0);
    chk("start_run_flag", {31'd0, bus.FLAG_timer}, 32'd0);
    chk("start_run_pid", {29'd0, bus.current_pid}, 32'd0);
    chk("start_run_busy", {31'd0, bus.busy}, 32'd0);
    chk("start_pc_hold", bus.pc_load, 32'h100);
    start();
    chk("start_in_run_ignored", {31'd0, bus.busy}, 32'd0);

    // 2: round-robin preemption
    irq(32'h140);
    chk("irq_save_busy", {31'd0, bus.busy}, 32'd1);
    chk("irq_save_valid", {31'd0, bus.pc_load_valid}, 32'd0);
    tick();
    chk("irq_sel_valid", {31'd0, bus.pc_load_valid}, 32'd0);
    tick();
    chk("irq1_valid", {31'd0, bus.pc_load_valid}, 32'd1);
    chk("irq1_flag", {31'd0, bus.FLAG_timer}, 32'd1);
    chk("irq1_pc_load", bus.pc_load, 32'h200);
    chk("irq1_quantum", bus.quantum, 32'd20);
    tick();
    chk("irq1_pid", {29'd0, bus.current_pid}, 32'd2);
    chk("irq1_busy", {31'd0, bus.busy}, 32'd0);
    chk("irq1_valid_off", {31'd0, bus.pc_load_valid}, 32'd0);
    irq(32'h240);
    tick();
    tick();
    chk("irq2_pc_load", bus.pc_load, 32'h140);
    chk("irq2_quantum", bus.quantum, 32'd10);
    tick();
    chk("irq2_pid", {29'd0, bus.current_pid}, 32'd0);

    // 3: finish
    fin();
    chk("fin_sel_valid", {31'd0, bus.pc_load_valid}, 32'd0);
    tick();
    chk("fin_load_valid", {31'd0, bus.pc_load_valid}, 32'd1);
    chk("fin_pc_load", bus.pc_load, 32'h240);
    chk("fin_quantum", bus.quantum, 32'd20);
    tick();
    chk("fin_pid", {29'd0, bus.current_pid}, 32'd2);
    fin();
    chk("fin2_sel_all_done", {31'd0, bus.all_done}, 32'd0);
    tick();
    chk("fin2_all_done", {31'd0, bus.all_done}, 32'd1);
    chk("fin2_valid", {31'd0, bus.pc_load_valid}, 32'd0);
    chk("fin2_busy", {31'd0, bus.busy}, 32'd1);
    irq(32'h999);
    tick();
    chk("idle_irq_valid", {31'd0, bus.pc_load_valid}, 32'd0);
    chk("idle_irq_busy", {31'd0, bus.busy}, 32'd1);
    chk("idle_irq_all_done", {31'd0, bus.all_done}, 32'd1);

    // 4: single process reselected
    create(3'd5, 32'h500, 32'd7);
    start();
    chk("s5_all_done_clr", {31'd0, bus.all_done}, 32'd0);
    tick();
    chk("s5_pc_load", bus.pc_load, 32'h500);
    tick();
    chk("s5_pid", {29'd0, bus.current_pid}, 32'd5);
    irq(32'h50C);
    tick();
    tick();
    chk("s5_resel_valid", {31'd0, bus.pc_load_valid}, 32'd1);
    chk("s5_resel_pc", bus.pc_load, 32'h50C);
    chk("s5_resel_quantum", bus.quantum, 32'd7);
    tick();
    chk("s5_resel_pid", {29'd0, bus.current_pid}, 32'd5);

    // 5a: create of the running slot is ignored
    create(3'd5, 32'hDEAD, 32'd99);
    irq(32'h510);
    tick();
    tick();
    chk("own_create_pc", bus.pc_load, 32'h510);
    chk("own_create_quantum", bus.quantum, 32'd7);
    tick();

    // 5b: interrupt and finish together deactivate without saving
    create(3'd3, 32'h300, 32'd30);
    bus.pc_current = 32'h5FF;
    bus.finish     = 1'b1;
    bus.interrupt  = 1'b1;
    tick();
    bus.finish     = 1'b0;
    bus.interrupt  = 1'b0;
    chk("both_sel_valid", {31'd0, bus.pc_load_valid}, 32'd0);
    tick();
    chk("both_load_valid", {31'd0, bus.pc_load_valid}, 32'd1);
    chk("both_pc_load", bus.pc_load, 32'h300);
    chk("both_quantum", bus.quantum, 32'd30);
    tick();
    chk("both_pid", {29'd0, bus.current_pid}, 32'd3);
    fin();
    tick();
    chk("both_all_done", {31'd0, bus.all_done}, 32'd1);

    // 5c: reset during SELECT aborts the switch and clears the table
    create(3'd1, 32'h111, 32'd11);
    start();
    reset = 1'b1;
    tick();
    chk_reset("mid_rst");
    reset = 1'b0;
    tick();
    chk("post_rst_valid0", {31'd0, bus.pc_load_valid}, 32'd0);
    chk("post_rst_flag0", {31'd0, bus.FLAG_timer}, 32'd0);
    tick();
    chk("post_rst_valid1", {31'd0, bus.pc_load_valid}, 32'd0);
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd1);
    start();
    tick();
    chk("empty_all_done", {31'd0, bus.all_done}, 32'd1);
    chk("empty_valid", {31'd0, bus.pc_load_valid}, 32'd0);

`ifdef SCHED_STATS_EN
    // 6: switch counter
    create(3'd0, 32'h100, 32'd10);
    create(3'd2, 32'h200, 32'd20);
    start();
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      irq(32'h1000 + 32'(k));
      tick();
      tick();
      tick();
    end
    chk("switch_count", bus.switch_count, 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
